// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus between the memory stage and dmem_ctrl
interface dmem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data memory with valid/ready requests, registered response and fault flag
// Misaligned halfword/word accesses are either split into two word beats or faulted.
module dmem_ctrl #(
   parameter int ADDR_W         = 16,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   dmem_ctrl_if.slave bus
);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BEAT2 = 1'b1;

   logic [31:0] mem_q [0:(1 << ADDR_W) - 1];

   logic [0:0]        state_q, state_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_W-1:0] w2_q, w2_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic              we_q, we_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       hi_data_q, hi_data_d;
   logic [3:0]        hi_mask_q, hi_mask_d;

   logic [ADDR_W-1:0] req_word;
   logic [1:0]        req_off;
   logic [3:0]        size_mask;
   logic [7:0]        lane_mask;
   logic [63:0]       lane_data;
   logic              f3_ok;
   logic              range_bad;
   logic              misal;
   logic              req_fault;

   logic [ADDR_W-1:0] rd_word;
   logic [31:0]       mem_rdata;
   logic [ADDR_W-1:0] mem_widx;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_we;

   function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] f3);
      logic [31:0] r;
      case (f3[1:0])
         2'b00:   r = f3[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   r = f3[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

   // Lanes are laid out over a two-word window: low nibble is beat 1, high nibble is beat 2.
   always_comb begin
      req_word = bus.req_addr[ADDR_W+1:2];
      req_off  = bus.req_addr[1:0];
      case (bus.req_funct3[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
      lane_mask = {4'b0, size_mask} << req_off;
      lane_data = {32'b0, bus.req_wdata} << {req_off, 3'b000};
      if (bus.req_we)
         f3_ok = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
      else
         f3_ok = (bus.req_funct3[1:0] != 2'b11) && (bus.req_funct3 != 3'b110);
      range_bad = |bus.req_addr[31:ADDR_W+2];
      misal     = |lane_mask[7:4];
      req_fault = !f3_ok || range_bad || (misal && (!MISALIGN_SPLIT || (&req_word)));
   end

   assign rd_word   = (state_q == S_BEAT2) ? w2_q : req_word;
   assign mem_rdata = mem_q[rd_word];

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_fault_d = rsp_fault_q;
      w2_d        = w2_q;
      off_d       = off_q;
      f3_d        = f3_q;
      we_d        = we_q;
      lo_d        = lo_q;
      hi_data_d   = hi_data_q;
      hi_mask_d   = hi_mask_q;
      mem_widx    = req_word;
      mem_wdata   = lane_data[31:0];
      mem_we      = 4'b0000;

      if (state_q == S_BEAT2) begin
         mem_widx    = w2_q;
         mem_wdata   = hi_data_q;
         mem_we      = we_q ? hi_mask_q : 4'b0000;
         rsp_valid_d = 1'b1;
         rsp_fault_d = 1'b0;
         rsp_rdata_d = we_q ? 32'b0 : load_ext(32'({mem_rdata, lo_q} >> {off_q, 3'b000}), f3_q);
         state_d     = S_IDLE;
      end else if (bus.req_valid) begin
         if (req_fault) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = 32'b0;
         end else if (misal) begin
            // Beat 1 commits now; the remaining bytes and read context wait for BEAT2.
            mem_we    = bus.req_we ? lane_mask[3:0] : 4'b0000;
            lo_d      = mem_rdata;
            w2_d      = req_word + ADDR_W'(1);
            off_d     = req_off;
            f3_d      = bus.req_funct3;
            we_d      = bus.req_we;
            hi_data_d = lane_data[63:32];
            hi_mask_d = lane_mask[7:4];
            state_d   = S_BEAT2;
         end else begin
            mem_we      = bus.req_we ? lane_mask[3:0] : 4'b0000;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_rdata_d = bus.req_we ? 32'b0
                                     : load_ext(mem_rdata >> {req_off, 3'b000}, bus.req_funct3);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we[i]) mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'b0;
         rsp_fault_q <= 1'b0;
         w2_q        <= '0;
         off_q       <= 2'b0;
         f3_q        <= 3'b0;
         we_q        <= 1'b0;
         lo_q        <= 32'b0;
         hi_data_q   <= 32'b0;
         hi_mask_q   <= 4'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
         w2_q        <= w2_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         we_q        <= we_d;
         lo_q        <= lo_d;
         hi_data_q   <= hi_data_d;
         hi_mask_q   <= hi_mask_d;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl (split and no-split instances)
module tb_dmem_ctrl;
   localparam int AW     = 6;
   localparam int NBYTES = 4 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_ctrl_if bs();
   dmem_ctrl_if bn();

   dmem_ctrl #(.ADDR_W(AW), .MISALIGN_SPLIT(1'b1)) u_split (.clk(clk), .rst_n(rst_n), .bus(bs));
   dmem_ctrl #(.ADDR_W(AW), .MISALIGN_SPLIT(1'b0)) u_nosplit (.clk(clk), .rst_n(rst_n), .bus(bn));

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        flt;
      int          lat;
   } vec_t;

   vec_t       tbl[$];
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] mm [2][NBYTES];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input bit ns, input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      if (ns) begin
         bn.req_valid = v; bn.req_we = we; bn.req_funct3 = f3; bn.req_addr = a; bn.req_wdata = d;
      end else begin
         bs.req_valid = v; bs.req_we = we; bs.req_funct3 = f3; bs.req_addr = a; bs.req_wdata = d;
      end
   endtask

   function automatic logic get_ready(input bit ns);
      return ns ? bn.req_ready : bs.req_ready;
   endfunction
   function automatic logic get_valid(input bit ns);
      return ns ? bn.rsp_valid : bs.rsp_valid;
   endfunction

   // Byte-level reference: ns=0 is the split instance, ns=1 the faulting one.
   function automatic void model(input bit ns, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic flt, output int lat);
      int n;
      bit bad_f3, misal;
      logic [31:0] v;
      n      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      bad_f3 = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      misal  = (int'(a[1:0]) + n) > 4;
      flt    = bad_f3 || (a >= 32'(NBYTES)) || ((longint'(a) + n) > NBYTES) || (misal && ns);
      rd     = 32'b0;
      lat    = (misal && !flt) ? 1 : 0;
      if (!flt) begin
         if (we) begin
            for (int i = 0; i < n; i++) mm[ns][int'(a) + i] = d[8*i +: 8];
         end else begin
            v = 32'b0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mm[ns][int'(a) + i];
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
         end
      end
   endfunction

   task automatic xact(input bit ns, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic flt,
                       output int lat, output logic rdy1);
      int  k;
      bit  done;
      rd = 'x; flt = 'x; lat = -1; rdy1 = 'x;
      k = 0;
      while (!get_ready(ns) && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      drive(ns, 1'b1, we, f3, a, d);
      @(posedge clk); #1;
      drive(ns, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
      rdy1 = get_ready(ns);
      done = 0;
      for (int c = 0; c < 4 && !done; c++) begin
         if (get_valid(ns)) begin
            done = 1;
            lat  = c;
            rd   = ns ? bn.rsp_rdata : bs.rsp_rdata;
            flt  = ns ? bn.rsp_fault : bs.rsp_fault;
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic run_chk(input string nm, input bit ns, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] e_rd,
                          input logic e_flt, input int e_lat);
      logic [31:0] rd;
      logic        flt, rdy1;
      int          lat;
      xact(ns, we, f3, a, d, rd, flt, lat, rdy1);
      chk({nm, " rdata"}, rd, e_rd);
      chk({nm, " fault"}, 32'(flt), 32'(e_flt));
      chk({nm, " latency"}, 32'(lat), 32'(e_lat));
      chk({nm, " ready after accept"}, 32'(rdy1), 32'(e_lat == 0));
   endtask

   task automatic model_chk(input string nm, input bit ns, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
      logic [31:0] e_rd;
      logic        e_flt;
      int          e_lat;
      model(ns, we, f3, a, d, e_rd, e_flt, e_lat);
      run_chk($sformatf("%s dut%0d we=%0d f3=%0d a=%08h", nm, ns, we, f3, a),
              ns, we, f3, a, d, e_rd, e_flt, e_lat);
   endtask

   task automatic init_mem(input bit ns);
      for (int i = 0; i < NBYTES / 4; i++)
         model_chk("init", ns, 1'b1, 3'b010, 32'(4 * i), 32'h0101_0101 * 32'(i));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] f3_pick [5];
      f3_pick = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      tbl.push_back('{1'b0, 3'd2, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd0, 32'h13,  32'h0, 32'hFFFFFFDE, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd4, 32'h13,  32'h0, 32'h000000DE, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd1, 32'h12,  32'h0, 32'hFFFFDEAD, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd5, 32'h12,  32'h0, 32'h0000DEAD, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd1, 32'h11,  32'h0, 32'hFFFFADBE, 1'b0, 0});
      tbl.push_back('{1'b1, 3'd2, 32'h21,  32'h11223344, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 3'd2, 32'h21,  32'h0, 32'h11223344, 1'b0, 1});
      tbl.push_back('{1'b0, 3'd2, 32'h20,  32'h0, 32'h22334408, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd2, 32'h24,  32'h0, 32'h09090911, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd5, 32'h23,  32'h0, 32'h00001122, 1'b0, 1});
      tbl.push_back('{1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b1, 3'd2, 32'hFE,  32'h12345678, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b0, 3'd2, 32'hFC,  32'h0, 32'h3F3F3F3F, 1'b0, 0});
      tbl.push_back('{1'b1, 3'd4, 32'h30,  32'h55667788, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b0, 3'd2, 32'h30,  32'h0, 32'h0C0C0C0C, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd3, 32'h30,  32'h0, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b0, 3'd2, 32'h80000010, 32'h0, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b1, 3'd1, 32'h3F,  32'h0000BEEF, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 3'd2, 32'h3C,  32'h0, 32'hEF0F0F0F, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd2, 32'h40,  32'h0, 32'h101010BE, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd1, 32'h3F,  32'h0, 32'hFFFFBEEF, 1'b0, 1});
      tbl.push_back('{1'b1, 3'd0, 32'h3E,  32'hFFFFFF80, 32'h0, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd0, 32'h3E,  32'h0, 32'hFFFFFF80, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd4, 32'h3E,  32'h0, 32'h00000080, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd2, 32'hFD,  32'h0, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b0, 3'd1, 32'hFE,  32'h0, 32'h00003F3F, 1'b0, 0});
      tbl.push_back('{1'b0, 3'd0, 32'hFF,  32'h0, 32'h0000003F, 1'b0, 0});

      drive(1'b0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
      drive(1'b1, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 32'(bs.req_ready), 32'd1);
      chk("reset rsp_valid", 32'(bs.rsp_valid), 32'd0);
      chk("reset rsp_rdata", bs.rsp_rdata, 32'd0);
      chk("reset rsp_fault", 32'(bs.rsp_fault), 32'd0);
      chk("reset ready nosplit", 32'(bn.req_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      init_mem(1'b0);
      init_mem(1'b1);

      // Back-to-back store then load to the same word.
      drive(1'b0, 1'b1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      @(posedge clk); #1;
      chk("b2b sw rsp_valid", 32'(bs.rsp_valid), 32'd1);
      chk("b2b sw rsp_fault", 32'(bs.rsp_fault), 32'd0);
      chk("b2b sw rsp_rdata", bs.rsp_rdata, 32'd0);
      chk("b2b ready", 32'(bs.req_ready), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
      @(posedge clk); #1;
      chk("b2b lw rsp_valid", 32'(bs.rsp_valid), 32'd1);
      chk("b2b lw rsp_rdata", bs.rsp_rdata, 32'hDEADBEEF);
      chk("b2b lw rsp_fault", 32'(bs.rsp_fault), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
      @(posedge clk); #1;
      chk("idle rsp_valid", 32'(bs.rsp_valid), 32'd0);
      chk("idle rdata hold", bs.rsp_rdata, 32'hDEADBEEF);

      foreach (tbl[i])
         run_chk($sformatf("vec%0d", i), 1'b0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                 tbl[i].rd, tbl[i].flt, tbl[i].lat);

      run_chk("nosplit sh@23",  1'b1, 1'b1, 3'd1, 32'h23, 32'h0000CAFE, 32'h0, 1'b1, 0);
      run_chk("nosplit lw@22",  1'b1, 1'b0, 3'd2, 32'h22, 32'h0, 32'h0, 1'b1, 0);
      run_chk("nosplit sw@21",  1'b1, 1'b1, 3'd2, 32'h21, 32'h11223344, 32'h0, 1'b1, 0);
      run_chk("nosplit lw@20",  1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h08080808, 1'b0, 0);
      run_chk("nosplit lw@24",  1'b1, 1'b0, 3'd2, 32'h24, 32'h0, 32'h09090909, 1'b0, 0);
      run_chk("nosplit lhu@21", 1'b1, 1'b0, 3'd5, 32'h21, 32'h0, 32'h00000808, 1'b0, 0);

      // Reset while the split store sits in BEAT2: beat-1 bytes stay, beat-2 word untouched.
      drive(1'b0, 1'b1, 1'b1, 3'd2, 32'h31, 32'hAABBCCDD);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
      chk("beat2 ready low", 32'(bs.req_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst rsp_valid", 32'(bs.rsp_valid), 32'd0);
      chk("async rst ready", 32'(bs.req_ready), 32'd1);
      chk("async rst rdata", bs.rsp_rdata, 32'd0);
      chk("async rst fault", 32'(bs.rsp_fault), 32'd0);
      @(posedge clk); #1;
      chk("in rst rsp_valid", 32'(bs.rsp_valid), 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post rst rsp_valid", 32'(bs.rsp_valid), 32'd0);
      run_chk("rst beat1 word", 1'b0, 1'b0, 3'd2, 32'h30, 32'h0, 32'hBBCCDD0C, 1'b0, 0);
      run_chk("rst beat2 word", 1'b0, 1'b0, 3'd2, 32'h34, 32'h0, 32'h0D0D0D0D, 1'b0, 0);

      init_mem(1'b0);
      for (int i = 0; i < 400; i++) begin
         bit          ns;
         logic        we;
         logic [2:0]  f3;
         logic [31:0] a;
         ns = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : f3_pick[$urandom_range(0, 4)];
         a  = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, NBYTES + 3));
         model_chk("rand", ns, we, f3, a, 32'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
